// File: rtl/sia_wbm_if.sv
// Wishbone B.4 pipelined bus bundle between the SIA bus master and the sia_wb register slave.
// Signal names and suffixes are given from the master's point of view.
interface sia_wbm_if;
    logic [2:0]  adr_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [1:0]  sel_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        ack_i;
    logic        stall_i;

    modport master (
        output adr_o, we_o, cyc_o, stb_o, sel_o, dat_o,
        input  dat_i, ack_i, stall_i
    );

    modport slave (
        input  adr_o, we_o, cyc_o, stb_o, sel_o, dat_o,
        output dat_i, ack_i, stall_i
    );
endinterface

// File: rtl/sia_wbm.sv
// Polls the SIA STATUS register and moves words between the SIA data register and
// a pair of ready/valid streams, so the SIA can run without a CPU.
//
// state     | meaning
// S_IDLE    | counting down the poll gap, no bus cycle
// S_ST_REQ  | STATUS read strobe presented, waiting for stall release
// S_ST_WAIT | STATUS read accepted, waiting for ack
// S_RD_REQ  | DATA read strobe presented
// S_RD_WAIT | DATA read accepted, waiting for ack
// S_WR_REQ  | DATA write strobe presented
// S_WR_WAIT | DATA write accepted, waiting for ack
module sia_wbm #(
    parameter logic [2:0] ADR_STATUS = 3'd1,
    parameter logic [2:0] ADR_DATA   = 3'd2,
    parameter int         RXNE_BIT   = 0,
    parameter int         TXNF_BIT   = 1,
    parameter logic [7:0] TIMEOUT    = 8'd255,
    parameter logic [7:0] POLL_GAP   = 8'd4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    sia_wbm_if.master    wb,
    output logic [15:0]  rxd_o,
    output logic         rxd_valid_o,
    input  logic         rxd_ready_i,
    input  logic [15:0]  txd_i,
    input  logic         txd_valid_i,
    output logic         txd_ready_o,
    output logic         error_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ST_REQ, S_ST_WAIT, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT
    } state_t;

    state_t      state_q;
    logic [2:0]  adr_q;
    logic        we_q, cyc_q, stb_q, err_q, last_wr_q;
    logic [1:0]  sel_q;
    logic [15:0] dat_q;
    logic [7:0]  gap_q, to_q;
    logic [15:0] rxd_q, rxd_d, txh_q, txh_d;
    logic        rxv_q, rxv_d, txr_q, txr_d;

    logic is_req, is_wait, is_status, xfer_done, rd_fire, wr_fire, rd_ok, wr_ok;

    assign is_req    = (state_q == S_ST_REQ) || (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign is_wait   = (state_q == S_ST_WAIT) || (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
    assign is_status = (state_q == S_ST_REQ) || (state_q == S_ST_WAIT);

    // An ack counts in REQ only on the edge that also accepts the strobe.
    assign xfer_done = cyc_q && wb.ack_i && (is_wait || (is_req && !wb.stall_i));
    assign rd_fire   = xfer_done && ((state_q == S_RD_REQ) || (state_q == S_RD_WAIT));
    assign wr_fire   = xfer_done && ((state_q == S_WR_REQ) || (state_q == S_WR_WAIT));
    assign rd_ok     = wb.dat_i[RXNE_BIT] && !rxv_q;
    assign wr_ok     = wb.dat_i[TXNF_BIT] && !txr_q;

    always_comb begin
        rxd_d = rxd_q;
        rxv_d = rxv_q;
        txh_d = txh_q;
        txr_d = txr_q;
        if (rxd_ready_i) rxv_d = 1'b0;
        if (rd_fire) begin
            rxv_d = 1'b1;
            rxd_d = wb.dat_i;
        end
        if (txd_valid_i && txr_q) begin
            txh_d = txd_i;
            txr_d = 1'b0;
        end
        if (wr_fire) txr_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rxd_q <= 16'h0000;
            rxv_q <= 1'b0;
            txh_q <= 16'h0000;
            txr_q <= 1'b1;
        end else begin
            rxd_q <= rxd_d;
            rxv_q <= rxv_d;
            txh_q <= txh_d;
            txr_q <= txr_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            adr_q     <= 3'd0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            sel_q     <= 2'b00;
            dat_q     <= 16'h0000;
            err_q     <= 1'b0;
            gap_q     <= 8'd0;
            to_q      <= 8'd0;
            last_wr_q <= 1'b1;
        end else begin
            err_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (gap_q != 8'd0) begin
                    gap_q <= gap_q - 8'd1;
                end else begin
                    state_q <= S_ST_REQ;
                    adr_q   <= ADR_STATUS;
                    we_q    <= 1'b0;
                    dat_q   <= 16'h0000;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    sel_q   <= 2'b11;
                    to_q    <= 8'd0;
                end
            end else if (xfer_done) begin
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                we_q    <= 1'b0;
                sel_q   <= 2'b00;
                dat_q   <= 16'h0000;
                state_q <= S_IDLE;
                gap_q   <= 8'd0;
                if (is_status) begin
                    // last_wr_q resets to 1 so that a tie goes to RX first.
                    if (rd_ok && (!wr_ok || last_wr_q)) begin
                        state_q   <= S_RD_REQ;
                        adr_q     <= ADR_DATA;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        sel_q     <= 2'b11;
                        to_q      <= 8'd0;
                        last_wr_q <= 1'b0;
                    end else if (wr_ok) begin
                        state_q   <= S_WR_REQ;
                        adr_q     <= ADR_DATA;
                        we_q      <= 1'b1;
                        dat_q     <= txh_q;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        sel_q     <= 2'b11;
                        to_q      <= 8'd0;
                        last_wr_q <= 1'b1;
                    end else begin
                        gap_q <= POLL_GAP;
                    end
                end
            end else if (to_q == TIMEOUT - 8'd1) begin
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                we_q    <= 1'b0;
                sel_q   <= 2'b00;
                dat_q   <= 16'h0000;
                err_q   <= 1'b1;
                state_q <= S_IDLE;
                gap_q   <= POLL_GAP;
            end else begin
                to_q <= to_q + 8'd1;
                if (is_req && !wb.stall_i) begin
                    stb_q <= 1'b0;
                    case (state_q)
                        S_ST_REQ: state_q <= S_ST_WAIT;
                        S_RD_REQ: state_q <= S_RD_WAIT;
                        default:  state_q <= S_WR_WAIT;
                    endcase
                end
            end
        end
    end

    assign wb.adr_o    = adr_q;
    assign wb.we_o     = we_q;
    assign wb.cyc_o    = cyc_q;
    assign wb.stb_o    = stb_q;
    assign wb.sel_o    = sel_q;
    assign wb.dat_o    = dat_q;
    assign rxd_o       = rxd_q;
    assign rxd_valid_o = rxv_q;
    assign txd_ready_o = txr_q;
    assign error_o     = err_q;

endmodule

// File: tb/tb_sia_wbm.sv
// Directed bench for sia_wbm: the initial block plays the sia_wb slave one bus cycle
// at a time and compares against hand-computed expectations.
module tb_sia_wbm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rxd;
    logic        rxd_valid, rxd_ready, txd_valid, txd_ready, error;
    logic [15:0] txd;
    int          n_cmp = 0;
    int          n_err = 0;

    sia_wbm_if wb ();

    sia_wbm dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .wb          (wb.master),
        .rxd_o       (rxd),
        .rxd_valid_o (rxd_valid),
        .rxd_ready_i (rxd_ready),
        .txd_i       (txd),
        .txd_valid_i (txd_valid),
        .txd_ready_o (txd_ready),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a strobe; exp_w is the number of idle negedges expected, -1 to skip.
    task automatic wait_stb(input string tag, input int exp_w);
        int w = 0;
        while (wb.stb_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_stb"}, 32'(wb.stb_o), 1);
        if (exp_w >= 0) check({tag, "_gap"}, w, exp_w);
    endtask

    task automatic serve(input string tag, input logic [2:0] adr, input logic we,
                         input logic [15:0] dat, input logic [15:0] rdata, input int nstall,
                         input logic same, input logic next_stb, input int exp_w);
        int hi = 1;
        wait_stb(tag, exp_w);
        check({tag, "_adr"}, 32'(wb.adr_o), 32'(adr));
        check({tag, "_we"},  32'(wb.we_o), 32'(we));
        check({tag, "_sel"}, 32'(wb.sel_o), 2'b11);
        check({tag, "_dat"}, 32'(wb.dat_o), 32'(dat));
        if (nstall > 0) begin
            wb.stall_i = 1'b1;
            for (int k = 0; k < nstall; k++) begin
                @(negedge clk);
                if (wb.stb_o === 1'b1) hi++;
            end
            wb.stall_i = 1'b0;
            check({tag, "_stb_len"}, hi, nstall + 1);
        end
        if (!same) begin
            @(negedge clk);
            check({tag, "_wait"}, 32'({wb.cyc_o, wb.stb_o}), 2'b10);
        end
        wb.ack_i = 1'b1;
        wb.dat_i = rdata;
        @(negedge clk);
        wb.ack_i = 1'b0;
        wb.dat_i = 16'h0000;
        check({tag, "_after"}, 32'({wb.cyc_o, wb.stb_o}), 32'({next_stb, next_stb}));
    endtask

    task automatic offer_tx(input logic [15:0] w);
        txd = w;
        txd_valid = 1'b1;
        @(negedge clk);
        txd_valid = 1'b0;
        check("tx_taken", 32'(txd_ready), 0);
    endtask

    task automatic drain_rx;
        rxd_ready = 1'b1;
        @(negedge clk);
        rxd_ready = 1'b0;
        check("rx_drained", 32'(rxd_valid), 0);
    endtask

    initial begin
        int hi;
        rst_n = 1'b0;
        rxd_ready = 1'b0;
        txd_valid = 1'b0;
        txd = 16'h0000;
        wb.dat_i = 16'h0000;
        wb.ack_i = 1'b0;
        wb.stall_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc_stb", 32'({wb.cyc_o, wb.stb_o, wb.we_o}), 0);
        check("rst_adr_sel_dat", 32'({wb.adr_o, wb.sel_o, wb.dat_o}), 0);
        check("rst_stream", 32'({rxd_valid, txd_ready, error}), 3'b010);
        check("rst_rxd", 32'(rxd), 0);
        rst_n = 1'b1;

        // RX path and hold-full blocking
        serve("st0", 3'd1, 1'b0, 16'h0, 16'h0001, 0, 1'b0, 1'b1, 1);
        serve("rd0", 3'd2, 1'b0, 16'h0, 16'h00A5, 0, 1'b0, 1'b0, 0);
        check("rd0_valid", 32'(rxd_valid), 1);
        check("rd0_data", 32'(rxd), 16'h00A5);
        serve("st1", 3'd1, 1'b0, 16'h0, 16'h0001, 0, 1'b1, 1'b0, 1);
        serve("st2", 3'd1, 1'b0, 16'h0, 16'h0001, 0, 1'b0, 1'b0, 5);
        check("hold_data", 32'({rxd_valid, rxd}), {1'b1, 16'h00A5});
        rxd_ready = 1'b1;
        txd = 16'h0155;
        txd_valid = 1'b1;
        @(negedge clk);
        rxd_ready = 1'b0;
        txd_valid = 1'b0;
        check("rx_drained0", 32'(rxd_valid), 0);
        check("tx_taken0", 32'(txd_ready), 0);

        // stray ack between cycles
        wb.ack_i = 1'b1;
        wb.dat_i = 16'hFFFF;
        @(negedge clk);
        wb.ack_i = 1'b0;
        wb.dat_i = 16'h0000;
        check("stray_ack", 32'({rxd_valid, wb.cyc_o, txd_ready}), 0);

        // TX write with a stalled strobe
        serve("st3", 3'd1, 1'b0, 16'h0, 16'h0002, 0, 1'b0, 1'b1, 3);
        serve("wr0", 3'd2, 1'b1, 16'h0155, 16'h0, 3, 1'b0, 1'b0, 0);
        check("wr0_ready", 32'(txd_ready), 1);

        // both sides ready: read follows the write, then write follows the read
        offer_tx(16'h0AAA);
        serve("st4", 3'd1, 1'b0, 16'h0, 16'h0003, 0, 1'b0, 1'b1, 0);
        serve("rd1", 3'd2, 1'b0, 16'h0, 16'h1234, 0, 1'b0, 1'b0, 0);
        check("rd1_data", 32'({rxd_valid, rxd}), {1'b1, 16'h1234});
        drain_rx();
        serve("st5", 3'd1, 1'b0, 16'h0, 16'h0003, 0, 1'b0, 1'b1, 0);
        serve("wr1", 3'd2, 1'b1, 16'h0AAA, 16'h0, 0, 1'b1, 1'b0, 0);
        check("wr1_ready", 32'(txd_ready), 1);

        // write never acked: abort, then retry
        offer_tx(16'h0777);
        serve("st6", 3'd1, 1'b0, 16'h0, 16'h0002, 0, 1'b0, 1'b1, 0);
        wait_stb("wr2", 0);
        check("wr2_dat", 32'({wb.adr_o, wb.we_o, wb.dat_o}), {3'd2, 1'b1, 16'h0777});
        hi = 0;
        while (wb.cyc_o === 1'b1 && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        check("to_len", hi, 255);
        check("to_err", 32'({error, wb.stb_o}), 2'b10);
        @(negedge clk);
        check("to_err_pulse", 32'(error), 0);
        check("to_txh_kept", 32'(txd_ready), 0);
        serve("st7", 3'd1, 1'b0, 16'h0, 16'h0002, 0, 1'b0, 1'b1, 4);
        serve("wr3", 3'd2, 1'b1, 16'h0777, 16'h0, 0, 1'b0, 1'b0, 0);
        check("wr3_ready", 32'(txd_ready), 1);

        // reset in the middle of a write
        offer_tx(16'h0101);
        serve("st8", 3'd1, 1'b0, 16'h0, 16'h0002, 0, 1'b0, 1'b1, 0);
        wait_stb("wr4", 0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_bus", 32'({wb.cyc_o, wb.stb_o}), 0);
        check("mid_rst_tx", 32'(txd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        serve("st9", 3'd1, 1'b0, 16'h0, 16'h0002, 0, 1'b1, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
